// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types and lane-merge helper for the 1RW+1R SRAM
package sram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } sram_state_e;

    // Widest word lane_merge can handle; callers zero-extend into this width.
    localparam int LM_MAX_WIDTH = 1024;
    localparam int LM_IDX_BITS  = 10;

    // Replace the lanes of old_word whose mask bit is set with new_word.
    // Mask bit i covers bits [i*lane_width +: lane_width].
    function automatic logic [LM_MAX_WIDTH-1:0] lane_merge(
        input logic [LM_MAX_WIDTH-1:0] old_word,
        input logic [LM_MAX_WIDTH-1:0] new_word,
        input logic [LM_MAX_WIDTH-1:0] mask,
        input int                      lane_width
    );
        logic [LM_MAX_WIDTH-1:0] merged;
        merged = old_word;
        for (int b = 0; b < LM_MAX_WIDTH; b++) begin
            if (mask[LM_IDX_BITS'(b / lane_width)]) begin
                merged[b] = new_word[b];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_clear_ctrl.sv
// rtl/sram_clear_ctrl.sv - clear-sweep FSM, address counter and ready flag
module sram_clear_ctrl
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clr_req,
    output logic                  o_ready,
    output logic                  o_clr_we,
    output logic [ADDR_WIDTH-1:0] o_clr_addr
);

    sram_state_e           r_state;
    sram_state_e           w_next_state;
    logic [ADDR_WIDTH-1:0] r_clr_addr;
    logic                  w_sweep_done;

    // State register; reset lands in the sweep only when clear-on-reset is enabled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            if (CLEAR_ON_RESET != 0) begin
                r_state <= ST_CLEAR;
            end else begin
                r_state <= ST_READY;
            end
        end else begin
            r_state <= w_next_state;
        end
    end

    // Sweep address: walks 0..DEPTH-1 while clearing, parked at 0 otherwise.
    always_ff @(posedge i_clk) begin
        if (i_rst || (r_state == ST_READY)) begin
            r_clr_addr <= '0;
        end else begin
            r_clr_addr <= r_clr_addr + ADDR_WIDTH'(1);
        end
    end

    // Next state and outputs; clr_req is only honoured while ready.
    always_comb begin
        w_next_state = r_state;
        w_sweep_done = 1'b0;
        o_ready      = 1'b0;
        o_clr_we     = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                o_clr_we = !i_rst;
                if (&r_clr_addr) begin
                    w_sweep_done = 1'b1;
                end
                if (w_sweep_done) begin
                    w_next_state = ST_READY;
                end
            end
            ST_READY: begin
                o_ready = 1'b1;
                if (i_clr_req) begin
                    w_next_state = ST_CLEAR;
                end
            end
        endcase
    end

    assign o_clr_addr = r_clr_addr;

endmodule

// File: rtl/sram_1rw1r_param.sv
// rtl/sram_1rw1r_param.sv - parametrised 1RW+1R SRAM with clear sweep and bypass
module sram_1rw1r_param
    import sram_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 8,
    parameter int                    WMASK_WIDTH    = 8,
    parameter int                    BYPASS         = 1,
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
    localparam int                   NUM_WMASKS     = DATA_WIDTH / WMASK_WIDTH,
    localparam int                   RAM_DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    output logic                  rvalid0,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic                  rvalid1,
    input  logic                  clr_req,
    output logic                  ready
);

    if (DATA_WIDTH % WMASK_WIDTH != 0) begin : g_bad_wmask
        $error("sram_1rw1r_param: DATA_WIDTH must be a multiple of WMASK_WIDTH");
    end
    if (DATA_WIDTH > LM_MAX_WIDTH) begin : g_bad_width
        $error("sram_1rw1r_param: DATA_WIDTH exceeds lane_merge capacity");
    end

    logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] r_dout0;
    logic [DATA_WIDTH-1:0] r_dout1;
    logic                  r_rvalid0;
    logic                  r_rvalid1;

    logic                  w_ready;
    logic                  w_clr_we;
    logic [ADDR_WIDTH-1:0] w_clr_addr;
    logic                  w_access;
    logic                  w_rd0;
    logic                  w_wr0;
    logic                  w_rd1;
    logic                  w_hit;
    logic [DATA_WIDTH-1:0] w_old0;
    logic [DATA_WIDTH-1:0] w_old1;
    logic [DATA_WIDTH-1:0] w_merged0;
    logic [DATA_WIDTH-1:0] w_rdata1;

    sram_clear_ctrl #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .CLEAR_ON_RESET(CLEAR_ON_RESET)
    ) u_clear_ctrl (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_clr_req (clr_req),
        .o_ready   (w_ready),
        .o_clr_we  (w_clr_we),
        .o_clr_addr(w_clr_addr)
    );

    // Port requests are dropped entirely while sweeping or in reset.
    assign w_access  = w_ready && !rst;
    assign w_rd0     = w_access && !csb0 && web0;
    assign w_wr0     = w_access && !csb0 && !web0 && (|wmask0);
    assign w_rd1     = w_access && !csb1;

    assign w_old0    = r_mem[addr0];
    assign w_old1    = r_mem[addr1];
    assign w_merged0 = DATA_WIDTH'(lane_merge(LM_MAX_WIDTH'(w_old0), LM_MAX_WIDTH'(din0),
                                              LM_MAX_WIDTH'(wmask0), WMASK_WIDTH));

    // The merged word is exactly what memory holds after the write, so bypass reuses it.
    assign w_hit     = (BYPASS != 0) && w_wr0 && (addr0 == addr1);
    assign w_rdata1  = w_hit ? w_merged0 : w_old1;

    // Array write: the sweep and port 0 never overlap because ports are gated by ready.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= CLEAR_VALUE;
        end else if (w_wr0) begin
            r_mem[addr0] <= w_merged0;
        end
    end

    // Registered read data and single-cycle valid strobes; dout holds when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout0   <= '0;
            r_dout1   <= '0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_rvalid0 <= w_rd0;
            r_rvalid1 <= w_rd1;
            if (w_rd0) begin
                r_dout0 <= w_old0;
            end
            if (w_rd1) begin
                r_dout1 <= w_rdata1;
            end
        end
    end

    assign dout0   = r_dout0;
    assign dout1   = r_dout1;
    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;
    assign ready   = w_ready;

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// tb/tb_sram_1rw1r_param.sv - bench for sram_1rw1r_param against a behavioural memory model
module tb_sram_1rw1r_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // DUT A: defaults (32x256, 8-bit lanes, bypass on)
    logic        a_csb0 = 1'b1, a_web0 = 1'b1, a_csb1 = 1'b1, a_clr = 1'b0;
    logic [3:0]  a_wmask0 = '0;
    logic [7:0]  a_addr0 = '0, a_addr1 = '0;
    logic [31:0] a_din0 = '0;
    logic [31:0] a_dout0, a_dout1;
    logic        a_rv0, a_rv1, a_ready;

    // DUT B: 64x16, 16-bit lanes, bypass off
    logic        b_csb0 = 1'b1, b_web0 = 1'b1, b_csb1 = 1'b1, b_clr = 1'b0;
    logic [3:0]  b_wmask0 = '0;
    logic [3:0]  b_addr0 = '0, b_addr1 = '0;
    logic [63:0] b_din0 = '0;
    logic [63:0] b_dout0, b_dout1;
    logic        b_rv0, b_rv1, b_ready;

    // Reference model state, index 0 = A, 1 = B
    logic [63:0] m_mem [2][256];
    int          m_clr [2];
    logic [63:0] e_d0 [2];
    logic [63:0] e_d1 [2];
    logic        e_rv0 [2];
    logic        e_rv1 [2];

    int n_tests = 0;
    int n_fail  = 0;
    int rd_addrs [3] = '{0, 128, 255};

    always #5 clk = ~clk;

    sram_1rw1r_param u_a (
        .clk(clk), .rst(rst),
        .csb0(a_csb0), .web0(a_web0), .wmask0(a_wmask0), .addr0(a_addr0), .din0(a_din0),
        .dout0(a_dout0), .rvalid0(a_rv0),
        .csb1(a_csb1), .addr1(a_addr1), .dout1(a_dout1), .rvalid1(a_rv1),
        .clr_req(a_clr), .ready(a_ready)
    );

    sram_1rw1r_param #(
        .DATA_WIDTH(64), .ADDR_WIDTH(4), .WMASK_WIDTH(16), .BYPASS(0), .CLEAR_ON_RESET(1)
    ) u_b (
        .clk(clk), .rst(rst),
        .csb0(b_csb0), .web0(b_web0), .wmask0(b_wmask0), .addr0(b_addr0), .din0(b_din0),
        .dout0(b_dout0), .rvalid0(b_rv0),
        .csb1(b_csb1), .addr1(b_addr1), .dout1(b_dout1), .rvalid1(b_rv1),
        .clr_req(b_clr), .ready(b_ready)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    // One clock edge of the memory as described by its rules: reset, sweep, or service.
    task automatic model_edge(input int d, input logic csb0, input logic web0,
                              input logic [3:0] wm, input int a0, input logic [63:0] din,
                              input logic csb1, input int a1, input logic clr);
        int          depth;
        int          lw;
        logic        byp;
        logic [63:0] nw;
        depth = (d == 0) ? 256 : 16;
        lw    = (d == 0) ? 8 : 16;
        byp   = (d == 0);
        if (rst) begin
            e_d0[d] = '0; e_d1[d] = '0; e_rv0[d] = 1'b0; e_rv1[d] = 1'b0;
            m_clr[d] = depth;
        end else if (m_clr[d] > 0) begin
            e_rv0[d] = 1'b0; e_rv1[d] = 1'b0;
            m_clr[d]--;
            if (m_clr[d] == 0) begin
                for (int i = 0; i < depth; i++) m_mem[d][i] = '0;
            end
        end else begin
            nw = m_mem[d][a0];
            for (int b = 0; b < 4 * lw; b++) begin
                if (wm[2'(b / lw)]) nw[b] = din[b];
            end
            e_rv1[d] = !csb1;
            if (!csb1) e_d1[d] = (byp && !csb0 && !web0 && a0 == a1) ? nw : m_mem[d][a1];
            e_rv0[d] = !csb0 && web0;
            if (!csb0 && web0) e_d0[d] = m_mem[d][a0];
            if (!csb0 && !web0) m_mem[d][a0] = nw;
            if (clr) m_clr[d] = depth;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0, a_csb0, a_web0, a_wmask0, int'(a_addr0), {32'b0, a_din0},
                   a_csb1, int'(a_addr1), a_clr);
        model_edge(1, b_csb0, b_web0, b_wmask0, int'(b_addr0), b_din0,
                   b_csb1, int'(b_addr1), b_clr);
        #1;
        chk("a.ready",   {63'b0, a_ready}, {63'b0, (m_clr[0] == 0)});
        chk("a.rvalid0", {63'b0, a_rv0},   {63'b0, e_rv0[0]});
        chk("a.rvalid1", {63'b0, a_rv1},   {63'b0, e_rv1[0]});
        chk("a.dout0",   {32'b0, a_dout0}, e_d0[0]);
        chk("a.dout1",   {32'b0, a_dout1}, e_d1[0]);
        chk("b.ready",   {63'b0, b_ready}, {63'b0, (m_clr[1] == 0)});
        chk("b.rvalid0", {63'b0, b_rv0},   {63'b0, e_rv0[1]});
        chk("b.rvalid1", {63'b0, b_rv1},   {63'b0, e_rv1[1]});
        chk("b.dout0",   b_dout0, e_d0[1]);
        chk("b.dout1",   b_dout1, e_d1[1]);
    endtask

    task automatic idle();
        a_csb0 = 1'b1; a_web0 = 1'b1; a_csb1 = 1'b1; a_clr = 1'b0; a_wmask0 = '0;
        b_csb0 = 1'b1; b_web0 = 1'b1; b_csb1 = 1'b1; b_clr = 1'b0; b_wmask0 = '0;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) m_clr[d] = 0;

        // Reset, then requests during the power-up sweep must be ignored
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst.a_ready", {63'b0, a_ready}, 64'd0);
        chk("rst.a_dout1", {32'b0, a_dout1}, 64'd0);
        for (int i = 0; i < 256; i++) begin
            a_csb0 = 1'b0; a_web0 = 1'b1; a_addr0 = 8'($urandom);
            a_csb1 = 1'b0; a_addr1 = 8'($urandom);
            step();
            chk("sweep.no_rvalid", {62'b0, a_rv0, a_rv1}, 64'd0);
            if (i == 14) chk("b.ready_at_15", {63'b0, b_ready}, 64'd0);
            if (i == 15) chk("b.ready_at_16", {63'b0, b_ready}, 64'd1);
            if (i == 254) chk("a.ready_at_255", {63'b0, a_ready}, 64'd0);
        end
        chk("a.ready_at_256", {63'b0, a_ready}, 64'd1);
        idle();

        // Port 1 reads of the cleared array
        for (int k = 0; k < 3; k++) begin
            a_csb1 = 1'b0; a_addr1 = 8'(rd_addrs[k]);
            step();
            chk("clr.rd1_data", {32'b0, a_dout1}, 64'd0);
            chk("clr.rd1_valid", {63'b0, a_rv1}, 64'd1);
            a_csb1 = 1'b1;
            step();
            chk("clr.rd1_strobe", {63'b0, a_rv1}, 64'd0);
        end

        // Masked write merge
        a_csb0 = 1'b0; a_web0 = 1'b0; a_addr0 = 8'h10; a_wmask0 = 4'hF; a_din0 = 32'hDEADBEEF;
        step();
        a_wmask0 = 4'h5; a_din0 = 32'h11223344;
        step();
        a_web0 = 1'b1;
        step();
        chk("mask.rd0", {32'b0, a_dout0}, 64'h00000000_DE22BE44);
        idle();

        // Collision: A bypasses, B returns the pre-write word
        a_csb0 = 1'b0; a_web0 = 1'b0; a_addr0 = 8'h20; a_wmask0 = 4'hF; a_din0 = 32'hAAAAAAAA;
        b_csb0 = 1'b0; b_web0 = 1'b0; b_addr0 = 4'h5; b_wmask0 = 4'hF; b_din0 = 64'hAAAAAAAA_AAAAAAAA;
        step();
        a_wmask0 = 4'b0011; a_din0 = 32'h55555555; a_csb1 = 1'b0; a_addr1 = 8'h20;
        b_wmask0 = 4'b0011; b_din0 = 64'h55555555_55555555; b_csb1 = 1'b0; b_addr1 = 4'h5;
        step();
        chk("coll.bypass", {32'b0, a_dout1}, 64'h00000000_AAAA5555);
        chk("coll.no_bypass", b_dout1, 64'hAAAAAAAA_AAAAAAAA);
        idle();
        a_csb1 = 1'b0; b_csb1 = 1'b0;
        step();
        chk("coll.after_a", {32'b0, a_dout1}, 64'h00000000_AAAA5555);
        chk("coll.after_b", b_dout1, 64'hAAAAAAAA_55555555);
        idle();

        // Fill with index, then clr_req together with a read
        for (int i = 0; i < 256; i++) begin
            a_csb0 = 1'b0; a_web0 = 1'b0; a_wmask0 = 4'hF; a_addr0 = 8'(i); a_din0 = 32'(i);
            step();
        end
        idle();
        a_clr = 1'b1; a_csb1 = 1'b0; a_addr1 = 8'd7;
        step();
        idle();
        chk("clrreq.rd1", {32'b0, a_dout1}, 64'd7);
        chk("clrreq.ready_drop", {63'b0, a_ready}, 64'd0);
        for (int i = 0; i < 256; i++) begin
            step();
            if (i == 254) chk("clrreq.ready_255", {63'b0, a_ready}, 64'd0);
        end
        chk("clrreq.ready_256", {63'b0, a_ready}, 64'd1);
        for (int i = 0; i < 256; i++) begin
            a_csb0 = 1'b0; a_web0 = 1'b1; a_addr0 = 8'(i);
            step();
            chk("clrreq.zero", {32'b0, a_dout0}, 64'd0);
        end
        idle();

        // Reset in the middle of a sweep restarts it
        a_clr = 1'b1;
        step();
        a_clr = 1'b0;
        for (int i = 0; i < 100; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (i == 254) chk("rstmid.ready_255", {63'b0, a_ready}, 64'd0);
        end
        chk("rstmid.ready_256", {63'b0, a_ready}, 64'd1);

        // B: per-lane masks on 8 addresses, read back on both ports
        for (int a = 0; a < 8; a++) begin
            b_csb0 = 1'b0; b_web0 = 1'b0; b_addr0 = 4'(a);
            b_wmask0 = 4'(1 << (a % 4)) | ((a >= 4) ? 4'(1 << ((a + 1) % 4)) : 4'd0);
            b_din0 = {$urandom, $urandom};
            step();
        end
        for (int a = 0; a < 8; a++) begin
            b_csb0 = 1'b0; b_web0 = 1'b1; b_addr0 = 4'(a); b_csb1 = 1'b0; b_addr1 = 4'(7 - a);
            step();
        end
        idle();

        // Randomised traffic on both instances
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(999) == 0);
            a_csb0 = $urandom_range(1) == 0; a_web0 = 1'($urandom); a_wmask0 = 4'($urandom);
            a_addr0 = 8'($urandom_range(31)); a_din0 = $urandom;
            a_csb1 = $urandom_range(1) == 0;
            a_addr1 = ($urandom_range(2) == 0) ? a_addr0 : 8'($urandom_range(31));
            a_clr = ($urandom_range(299) == 0);
            b_csb0 = $urandom_range(1) == 0; b_web0 = 1'($urandom); b_wmask0 = 4'($urandom);
            b_addr0 = 4'($urandom); b_din0 = {$urandom, $urandom};
            b_csb1 = $urandom_range(1) == 0;
            b_addr1 = ($urandom_range(2) == 0) ? b_addr0 : 4'($urandom);
            b_clr = ($urandom_range(299) == 0);
            step();
        end
        rst = 1'b0;
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_1rw1r_param.md
# sram_1rw1r_param

Parametrised single-clock 1RW+1R SRAM model for the LDPC encoder/decoder buffers, successor to the fixed 32x256 macro model. Generalises width, depth and write-mask granularity and adds a synchronous reset, an address-sweeping clear engine and a `ready` indication. It also adds `rvalid` strobes and configurable write-to-read bypass between the two ports. It drops in wherever codeword/message memories need a deterministic power-up state in simulation and FPGA builds.

## Interface
- `DATA_WIDTH`, 32, word width in bits.
- `ADDR_WIDTH`, 8, address bits; `RAM_DEPTH = 1 << ADDR_WIDTH` (derived, not overridable).
- `WMASK_WIDTH`, 8, bits per write-mask lane; `NUM_WMASKS = DATA_WIDTH / WMASK_WIDTH` (derived).
- `BYPASS`, 1, 1 = same-cycle port-1 read of the address port 0 writes returns new data; 0 = returns old data.
- `CLEAR_ON_RESET`, 1, 1 = run the clear sweep after `rst`.
- `CLEAR_VALUE`, '0, word written by the clear sweep.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `csb0` in 1: port 0 active-low select.
- `web0` in 1: port 0 active-low write enable.
- `wmask0` in NUM_WMASKS: per-lane write enable, lane i = bits [i*WMASK_WIDTH +: WMASK_WIDTH].
- `addr0` in ADDR_WIDTH: port 0 address.
- `din0` in DATA_WIDTH: port 0 write data.
- `dout0` out DATA_WIDTH: port 0 read data.
- `rvalid0` out 1: `dout0` updated this cycle.
- `csb1` in 1: port 1 active-low select.
- `addr1` in ADDR_WIDTH: port 1 address.
- `dout1` out DATA_WIDTH: port 1 read data.
- `rvalid1` out 1: `dout1` updated this cycle.
- `clr_req` in 1: one-cycle pulse starting a clear sweep.
- `ready` out 1: high when requests are accepted.

## Operation
- FSM states `ST_CLEAR`, `ST_READY`.
- `rst` forces `ST_CLEAR` if `CLEAR_ON_RESET`=1, else `ST_READY`.
- `clr_req` sampled high in `ST_READY` moves the FSM to `ST_CLEAR`. It is ignored while in `ST_CLEAR`.
- `ST_CLEAR` behaviour:
  - Counter `clr_addr` starts at 0 and writes `CLEAR_VALUE` to one full word per cycle.
  - After writing `RAM_DEPTH-1` the FSM goes to `ST_READY` on the next edge. The sweep takes exactly `RAM_DEPTH` cycles.
  - `ready`=0; `csb0`/`csb1` are ignored; no memory access, no `rvalid`.
- Port 0 write (`csb0`=0, `web0`=0, ready):
  - Only lanes with `wmask0[i]`=1 are updated.
  - `dout0` holds its value; `rvalid0`=0.
  - `wmask0`=0 performs no write.
- Port 0 read (`csb0`=0, `web0`=1): `dout0` <= mem[`addr0`], `rvalid0`=1.
- Port 1 read (`csb1`=0): `dout1` <= mem[`addr1`], `rvalid1`=1.
- Collision (port 0 write and port 1 read to the same address in the same cycle):
  - `BYPASS`=1: `dout1` = old word with the masked lanes replaced by `din0`. This equals the post-write memory content.
  - `BYPASS`=0: `dout1` = pre-write word.
  - Memory is updated identically in both modes.
- Unselected ports keep `dout` unchanged and `rvalid` low.

## Timing
- Inputs are sampled at posedge N. Read data and `rvalid` are registered at posedge N (latency 1). `rvalid` is a single-cycle strobe per request.
- A write sampled at posedge N is visible to reads sampled at posedge N+1 and later, on either port.
- Reset values: `dout0`=0, `dout1`=0, `rvalid0`=0, `rvalid1`=0, `ready`=`!CLEAR_ON_RESET`, `clr_addr`=0.
- `rst` during a sweep restarts it at address 0. Memory contents are not reset except by the sweep.
- `clr_req` and a port request in the same cycle in `ST_READY`: the request is serviced and the sweep starts next cycle. `ready` drops one cycle after `clr_req` is sampled.
- Elaboration fails (`$error`) if `DATA_WIDTH % WMASK_WIDTH != 0`.

## Structure
- Package `sram_pkg`: `sram_state_e` enum (`ST_CLEAR`, `ST_READY`). It also holds the function `lane_merge(old, new, mask)` used for both the masked write and the bypass path.
- One sub-module is natural: `sram_clear_ctrl`. It holds the FSM, `clr_addr` counter, `ready` and sweep done, and drives a clear-write enable/address into the array.
- The array, port logic and bypass stay in `sram_1rw1r_param`.

## Test plan
- Reset with defaults:
  - `ready` low for 256 cycles, then high.
  - Port 1 reads of addresses 0, 128 and 255 return 0x00000000 with `rvalid1` pulsed one cycle later.
  - Requests issued during the sweep produce no `rvalid`.
- Masked write:
  - Write 0xDEADBEEF to address 0x10 with `wmask0`=4'b1111.
  - Then write 0x11223344 with `wmask0`=4'b0101.
  - Port 0 read returns 0xDE22BE44.
- Collision: mem[0x20]=0xAAAAAAAA, then port 0 write 0x55555555 with mask 4'b0011 while port 1 reads 0x20.
  - `BYPASS`=1: `dout1`=0xAAAA5555.
  - `BYPASS`=0: `dout1`=0xAAAAAAAA.
  - A following port 1 read returns 0xAAAA5555 in both modes.
- `clr_req` after filling addresses 0..255 with the index:
  - `ready` drops, rises after 256 cycles.
  - All words read 0.
- `rst` asserted at sweep cycle 100: `ready` stays low for a full 256 cycles after `rst` deasserts.
- Parameter sweep with `DATA_WIDTH`=64, `WMASK_WIDTH`=16, `ADDR_WIDTH`=4:
  - Per-lane masks on 8 addresses.
  - `ready` after 16 cycles.
